// File: rtl/audio_dac_player.sv
// ============================================================================
// Module  : audio_dac_player
// Brief   : FIFO-buffered I2S mono-to-stereo serialiser for the WM8731 DAC.
//           Optional macro AUDIO_DAC_UNDERRUN_HOLD_EN repeats the last sample
//           on underrun instead of playing silence.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_dac_player #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_daclrck,
  output logic              o_aud_dacdat,
  output logic [CNT_W-1:0]  o_underrun_cnt,
  output logic              o_busy
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_FCNT_W = c_PTR_W + 1;
  localparam int c_BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_L = 3'd1,
    ST_PAD_L  = 3'd2,
    ST_SEND_R = 3'd3,
    ST_PAD_R  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_lrck_d;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_last;
  logic [c_BIT_W-1:0]  r_bitcnt;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_FCNT_W-1:0] r_count;

  logic              w_fall;
  logic              w_rise;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_in_right;
  logic              w_in_left;
  logic              w_left_start;
  logic              w_right_start;
  logic [DATA_W-1:0] w_underrun_val;
  logic [DATA_W-1:0] w_load_val;

  assign w_fall  = r_lrck_d & ~i_daclrck;
  assign w_rise  = ~r_lrck_d & i_daclrck;
  assign w_empty = (r_count == '0);
  assign o_ready = (r_count != c_FCNT_W'(FIFO_DEPTH));
  assign w_push  = i_valid & o_ready;

  assign w_in_right    = (r_state == ST_SEND_R) || (r_state == ST_PAD_R);
  assign w_in_left     = (r_state == ST_SEND_L) || (r_state == ST_PAD_L);
  assign w_left_start  = w_fall & i_en & (w_in_right || (r_state == ST_IDLE));
  assign w_right_start = w_rise & w_in_left;
  // Pop decision uses the registered count only, so a same-cycle push cannot bypass.
  assign w_pop         = w_left_start & ~w_empty;

`ifdef AUDIO_DAC_UNDERRUN_HOLD_EN
  assign w_underrun_val = r_last;
`else
  assign w_underrun_val = '0;
`endif

  assign w_load_val = w_empty ? w_underrun_val : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_lrck_d       <= 1'b0;
      r_shift        <= '0;
      r_last         <= '0;
      r_bitcnt       <= '0;
      o_aud_dacdat   <= 1'b0;
      o_underrun_cnt <= '0;
      o_busy         <= 1'b0;
    end else begin
      r_lrck_d <= i_daclrck;
      // LRCK edges take priority over the shifter, which truncates short frames.
      if (w_left_start) begin
        r_state      <= ST_SEND_L;
        r_shift      <= w_load_val;
        r_last       <= w_load_val;
        o_aud_dacdat <= w_load_val[DATA_W-1];
        r_bitcnt     <= '0;
        o_busy       <= 1'b1;
        if (w_empty && (o_underrun_cnt != '1))
          o_underrun_cnt <= o_underrun_cnt + 1'b1;
      end else if (w_right_start) begin
        r_state      <= ST_SEND_R;
        r_shift      <= r_last;
        o_aud_dacdat <= r_last[DATA_W-1];
        r_bitcnt     <= '0;
        o_busy       <= 1'b1;
      end else if (w_fall && w_in_right) begin
        r_state      <= ST_IDLE;
        o_aud_dacdat <= 1'b0;
        r_bitcnt     <= '0;
        o_busy       <= 1'b0;
      end else begin
        case (r_state)
          ST_SEND_L, ST_SEND_R: begin
            if (r_bitcnt == c_BIT_W'(DATA_W - 1)) begin
              r_state      <= (r_state == ST_SEND_L) ? ST_PAD_L : ST_PAD_R;
              o_aud_dacdat <= 1'b0;
            end else begin
              r_bitcnt     <= r_bitcnt + 1'b1;
              r_shift      <= r_shift << 1;
              o_aud_dacdat <= r_shift[DATA_W-2];
            end
          end
          default: o_aud_dacdat <= 1'b0;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
